bist_repair_sequencer: RTL

- Hardware sequencer for the self-repair flow: MBIST #1, fault capture, BIRA analysis, BISR repair enable, MBIST #2 on the repaired array.
- Sits between mbist_controller, bira_engine and the row/col address mux.
- Owns the MBIST-local reset, the start_bira pulse and repair_active.
- Reports one final result code.

---
 rtl/bira_pkg.sv | 38 +++
 rtl/bist_repair_sequencer_if.sv | 28 ++
 rtl/seq_watchdog.sv | 30 +++
 rtl/bist_repair_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bira_pkg.sv
// Shared types for the self-repair flow: fault records, sequencer states and result codes.
package bira_pkg;

   localparam int ROW_W = 8;
   localparam int COL_W = 8;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } fault_rec_t;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      M1_RST    = 4'd1,
      M1_RUN    = 4'd2,
      CAPTURE   = 4'd3,
      BIRA_GO   = 4'd4,
      BIRA_WAIT = 4'd5,
      M2_RST    = 4'd6,
      M2_RUN    = 4'd7,
      DONE      = 4'd8
   } seq_state_e;

   typedef enum logic [2:0] {
      RES_CLEAN        = 3'd0,
      RES_REPAIRED     = 3'd1,
      RES_UNREPAIRABLE = 3'd2,
      RES_REPAIR_FAIL  = 3'd3,
      RES_TIMEOUT      = 3'd4,
      RES_OVERFLOW     = 3'd5
   } seq_result_e;

   // MBIST is held in reset before the first launch and during both RST phases.
   function automatic logic mbist_held(input seq_state_e s);
      return (s == IDLE) || (s == M1_RST) || (s == M2_RST);
   endfunction

endpackage

// File: rtl/bist_repair_sequencer_if.sv
// Handshake bundle between the repair sequencer (master) and the MBIST/BIRA engines (slave).
interface bist_repair_sequencer_if
   import bira_pkg::*;
#(
   parameter int MAX_FAULTS = 8,
   parameter int FCNT_W     = 4
) ();
   logic                             mbist_rst_n;
   logic                             bist_done;
   logic                             bist_fail;
   logic [FCNT_W-1:0]                fault_count_in;
   fault_rec_t [MAX_FAULTS-1:0]      fault_list_in;
   logic                             start_bira;
   logic [FCNT_W-1:0]                bira_fault_count;
   fault_rec_t [MAX_FAULTS-1:0]      bira_fault_list;
   logic                             bira_done;
   logic                             bira_success;

   modport master (
      output mbist_rst_n, start_bira, bira_fault_count, bira_fault_list,
      input  bist_done, bist_fail, fault_count_in, fault_list_in, bira_done, bira_success
   );

   modport slave (
      input  mbist_rst_n, start_bira, bira_fault_count, bira_fault_list,
      output bist_done, bist_fail, fault_count_in, fault_list_in, bira_done, bira_success
   );
endinterface

// File: rtl/seq_watchdog.sv
// Clear/enable phase counter; expired flags the last cycle of a LIMIT-cycle phase.
module seq_watchdog #(
   parameter int LIMIT = 4096,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         expired
);
   logic [W-1:0] count_r;

   // Phase cycle counter, saturating at LIMIT so a long-lived phase cannot wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (en && (count_r != W'(LIMIT))) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count   = count_r;
   assign expired = (count_r == W'(LIMIT - 1));
endmodule

// File: rtl/bist_repair_sequencer.sv
// MBIST -> capture -> BIRA -> BISR -> MBIST sequencer with one final result code.
// Optional SEQ_CYCLE_COUNT_EN adds a saturating total_cycles busy counter.
module bist_repair_sequencer
   import bira_pkg::*;
#(
   parameter int MAX_FAULTS     = 8,
   parameter int FCNT_W         = 4,
   parameter int RST_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   bist_repair_sequencer_if.master  bus,
   output logic                     repair_active,
   output logic                     busy,
   output logic                     done,
   output logic [2:0]               result
`ifdef SEQ_CYCLE_COUNT_EN
   ,
   output logic [31:0]              total_cycles
`endif
);
   seq_state_e                  state_r, next_state_s;
   seq_result_e                 result_r, result_next_s;
   logic                        set_result_s, set_repair_s, launch_s, capture_s;
   logic                        wd_clr_s, wd_expired_s, hold_done_s;
   logic [TMR_W-1:0]            wd_count_s;
   logic                        mbist_rst_n_r, start_bira_r, busy_r, done_r, repair_active_r;
   logic [FCNT_W-1:0]           bira_fault_count_r;
   fault_rec_t [MAX_FAULTS-1:0] bira_fault_list_r;

   seq_watchdog #(.LIMIT(TIMEOUT_CYCLES), .W(TMR_W)) u_wd (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr_s),
      .en      (1'b1),
      .count   (wd_count_s),
      .expired (wd_expired_s)
   );

   // Next-state and result decode; the watchdog restarts on every state change.
   always_comb begin
      next_state_s  = state_r;
      result_next_s = result_r;
      set_result_s  = 1'b0;
      set_repair_s  = 1'b0;
      launch_s      = 1'b0;
      capture_s     = 1'b0;
      hold_done_s   = (wd_count_s == TMR_W'(RST_CYCLES - 1));
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               next_state_s = M1_RST;
               launch_s     = 1'b1;
            end else begin
               next_state_s = state_r;
            end
         end
         M1_RST: begin
            if (hold_done_s) next_state_s = M1_RUN;
            else             next_state_s = M1_RST;
         end
         M1_RUN: begin
            // A zero count marks the first RUN cycle, where a stale bist_done is ignored.
            if (bus.bist_done && (wd_count_s != '0)) begin
               next_state_s = CAPTURE;
               capture_s    = 1'b1;
            end else if (wd_expired_s) begin
               next_state_s  = DONE;
               set_result_s  = 1'b1;
               result_next_s = RES_TIMEOUT;
            end else begin
               next_state_s = M1_RUN;
            end
         end
         CAPTURE: begin
            set_result_s = 1'b1;
            if (bira_fault_count_r == '0) begin
               next_state_s  = DONE;
               result_next_s = bus.bist_fail ? RES_UNREPAIRABLE : RES_CLEAN;
            end else if (bira_fault_count_r > FCNT_W'(MAX_FAULTS)) begin
               next_state_s  = DONE;
               result_next_s = RES_OVERFLOW;
            end else begin
               next_state_s = BIRA_GO;
               set_result_s = 1'b0;
            end
         end
         BIRA_GO: begin
            next_state_s = BIRA_WAIT;
         end
         BIRA_WAIT: begin
            if (bus.bira_done) begin
               if (bus.bira_success) begin
                  next_state_s = M2_RST;
                  set_repair_s = 1'b1;
               end else begin
                  next_state_s  = DONE;
                  set_result_s  = 1'b1;
                  result_next_s = RES_UNREPAIRABLE;
               end
            end else if (wd_expired_s) begin
               next_state_s  = DONE;
               set_result_s  = 1'b1;
               result_next_s = RES_TIMEOUT;
            end else begin
               next_state_s = BIRA_WAIT;
            end
         end
         M2_RST: begin
            if (hold_done_s) next_state_s = M2_RUN;
            else             next_state_s = M2_RST;
         end
         M2_RUN: begin
            if (bus.bist_done && (wd_count_s != '0)) begin
               next_state_s  = DONE;
               set_result_s  = 1'b1;
               result_next_s = bus.bist_fail ? RES_REPAIR_FAIL : RES_REPAIRED;
            end else if (wd_expired_s) begin
               next_state_s  = DONE;
               set_result_s  = 1'b1;
               result_next_s = RES_TIMEOUT;
            end else begin
               next_state_s = M2_RUN;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
      wd_clr_s = (next_state_s != state_r);
   end

   // State register and outputs registered from the next state so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= IDLE;
         mbist_rst_n_r   <= 1'b0;
         start_bira_r    <= 1'b0;
         busy_r          <= 1'b0;
         done_r          <= 1'b0;
         result_r        <= RES_CLEAN;
         repair_active_r <= 1'b0;
      end else begin
         state_r       <= next_state_s;
         mbist_rst_n_r <= !mbist_held(next_state_s);
         start_bira_r  <= (next_state_s == BIRA_GO);
         busy_r        <= (next_state_s != IDLE) && (next_state_s != DONE);
         done_r        <= (next_state_s == DONE);
         if (set_result_s) result_r <= result_next_s;
         else              result_r <= result_r;
         if (launch_s)          repair_active_r <= 1'b0;
         else if (set_repair_s) repair_active_r <= 1'b1;
         else                   repair_active_r <= repair_active_r;
      end
   end

   // Fault snapshot for BIRA, taken as MBIST #1 completes so it leads start_bira.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bira_fault_count_r <= '0;
         bira_fault_list_r  <= '0;
      end else if (capture_s) begin
         bira_fault_count_r <= bus.fault_count_in;
         bira_fault_list_r  <= bus.fault_list_in;
      end else begin
         bira_fault_count_r <= bira_fault_count_r;
         bira_fault_list_r  <= bira_fault_list_r;
      end
   end

`ifdef SEQ_CYCLE_COUNT_EN
   logic [31:0] total_cycles_r;

   // Counts busy cycles of the current sequence; frozen once busy drops in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_cycles_r <= 32'd0;
      end else if (launch_s) begin
         total_cycles_r <= 32'd0;
      end else if (busy_r && (total_cycles_r != 32'hFFFF_FFFF)) begin
         total_cycles_r <= total_cycles_r + 32'd1;
      end else begin
         total_cycles_r <= total_cycles_r;
      end
   end

   assign total_cycles = total_cycles_r;
`endif

   assign bus.mbist_rst_n      = mbist_rst_n_r;
   assign bus.start_bira       = start_bira_r;
   assign bus.bira_fault_count = bira_fault_count_r;
   assign bus.bira_fault_list  = bira_fault_list_r;
   assign repair_active        = repair_active_r;
   assign busy                 = busy_r;
   assign done                 = done_r;
   assign result               = result_r;
endmodule
